// File: rtl/t2mi_pkg.sv
// Shared constants, FSM encoding and small helpers for the T2-MI TS scheduler.
package t2mi_pkg;

  localparam logic [7:0]  TS_LEN     = 8'd188;
  localparam logic [7:0]  TS_PAYLOAD = 8'd184;
  localparam logic [7:0]  TS_SYNC    = 8'h47;
  localparam logic [12:0] NULL_PID   = 13'h1FFF;
  localparam logic [7:0]  PTR_NONE   = 8'hFF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PK_START = 2'd1;
  localparam logic [1:0] ST_PK_RUN   = 2'd2;
  localparam logic [1:0] ST_NULL_RUN = 2'd3;

  // Null packet: header 47 1F FF 10 (PID 0x1FFF, payload only, CC 0), then stuffing.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = TS_SYNC;
      8'd1:    b = {3'b000, NULL_PID[12:8]};
      8'd2:    b = NULL_PID[7:0];
      8'd3:    b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] calc_pointer(input logic at_head, input logic [15:0] rem);
    logic [7:0] p;
    if (at_head) begin
      p = 8'd0;
    end else if (rem < {8'd0, TS_PAYLOAD}) begin
      p = rem[7:0];
    end else begin
      p = PTR_NONE;
    end
    return p;
  endfunction

endpackage

// File: rtl/t2mi_ts_scheduler_if.sv
// Bus bundle between the slot source, payload FIFO, packetizer and the scheduler.
interface t2mi_ts_scheduler_if #(parameter int LVL_W = 12);

  logic             slot;
  logic [LVL_W-1:0] fifo_lvl;
  logic             len_wr;
  logic [15:0]      len_in;
  logic             rd_ack;
  logic [7:0]       pk_data;
  logic             pk_ena;
  logic             pk_psync;
  logic             pk_start;
  logic [7:0]       pk_pointer;
  logic [7:0]       ts_data;
  logic             ts_ena;
  logic             ts_psync;
  logic             slot_miss;
  logic             lq_ovf;

  modport master (
    output slot, fifo_lvl, len_wr, len_in, rd_ack, pk_data, pk_ena, pk_psync,
    input  pk_start, pk_pointer, ts_data, ts_ena, ts_psync, slot_miss, lq_ovf
  );

  modport slave (
    input  slot, fifo_lvl, len_wr, len_in, rd_ack, pk_data, pk_ena, pk_psync,
    output pk_start, pk_pointer, ts_data, ts_ena, ts_psync, slot_miss, lq_ovf
  );

endinterface

// File: rtl/t2mi_len_fifo.sv
// Show-ahead synchronous FIFO holding queued T2-MI packet lengths.
module t2mi_len_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign wr_en_s = wr && !full;
  assign rd_en_s = rd && !empty;
  assign dout    = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/t2mi_ts_scheduler.sv
// Per 188-byte TS slot, runs either the T2-MI packetizer or a null packet, and
// tracks the current T2-MI packet boundary to give the packetizer its pointer.
module t2mi_ts_scheduler
  import t2mi_pkg::*;
#(
  parameter int LQ_DEPTH = 8,
  parameter int LVL_W    = 12
) (
  input  logic               CLK,
  input  logic               RST,
  t2mi_ts_scheduler_if.slave bus
);

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic        pk_start_r;
  logic [7:0]  pk_pointer_r;
  logic [7:0]  ts_data_r;
  logic        ts_ena_r;
  logic        ts_psync_r;
  logic        slot_miss_r;
  logic        lq_ovf_r;
  logic [15:0] rem_r;
  logic        at_head_r;
  logic        cur_valid_r;
  logic [15:0] lq_dout_s;
  logic        lq_full_s;
  logic        lq_empty_s;
  logic        load_s;
  logic        pop_s;
  logic        last_s;

  t2mi_len_fifo #(.DEPTH(LQ_DEPTH), .WIDTH(16)) u_len_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .wr    (bus.len_wr),
    .din   (bus.len_in),
    .rd    (pop_s),
    .dout  (lq_dout_s),
    .full  (lq_full_s),
    .empty (lq_empty_s)
  );

  // Reload when nothing is held or the last byte of the current packet is read now.
  always_comb begin
    load_s = 1'b0;
    if (!cur_valid_r) begin
      load_s = 1'b1;
    end else if (bus.rd_ack && (rem_r <= 16'd1)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  assign pop_s  = load_s && !lq_empty_s;
  assign last_s = (cnt_r == (TS_LEN - 8'd1));

  // Current T2-MI packet tracking; RD_ACK with no valid packet is ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rem_r       <= 16'd0;
      at_head_r   <= 1'b0;
      cur_valid_r <= 1'b0;
    end else if (load_s) begin
      if (!lq_empty_s) begin
        rem_r       <= lq_dout_s;
        at_head_r   <= 1'b1;
        cur_valid_r <= 1'b1;
      end else begin
        rem_r       <= 16'd0;
        at_head_r   <= 1'b0;
        cur_valid_r <= 1'b0;
      end
    end else if (bus.rd_ack) begin
      rem_r     <= rem_r - 16'd1;
      at_head_r <= 1'b0;
    end else begin
      rem_r <= rem_r;
    end
  end

  // Slot FSM; the pointer is captured once per packet and held through PK_RUN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      pk_start_r   <= 1'b0;
      pk_pointer_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 8'd0;
          if (bus.slot) begin
            if (cur_valid_r && (bus.fifo_lvl >= LVL_W'(TS_PAYLOAD))) begin
              state_r      <= ST_PK_START;
              pk_start_r   <= 1'b1;
              pk_pointer_r <= calc_pointer(at_head_r, rem_r);
            end else begin
              state_r <= ST_NULL_RUN;
            end
          end
        end
        ST_PK_START: begin
          pk_start_r <= 1'b0;
          state_r    <= ST_PK_RUN;
        end
        ST_PK_RUN: begin
          if (bus.pk_ena) begin
            if (last_s) begin
              state_r <= ST_IDLE;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        ST_NULL_RUN: begin
          if (last_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= 8'd0;
          pk_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slot_miss_r <= 1'b0;
      lq_ovf_r    <= 1'b0;
    end else begin
      if (bus.slot && (state_r != ST_IDLE)) slot_miss_r <= 1'b1;
      if (bus.len_wr && lq_full_s)          lq_ovf_r    <= 1'b1;
    end
  end

  // Registered TS output mux.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ts_data_r  <= 8'd0;
      ts_ena_r   <= 1'b0;
      ts_psync_r <= 1'b0;
    end else begin
      case (state_r)
        ST_PK_START, ST_PK_RUN: begin
          ts_data_r  <= bus.pk_data;
          ts_ena_r   <= bus.pk_ena;
          ts_psync_r <= bus.pk_psync;
        end
        ST_NULL_RUN: begin
          ts_data_r  <= null_byte(cnt_r);
          ts_ena_r   <= 1'b1;
          ts_psync_r <= (cnt_r == 8'd0);
        end
        default: begin
          ts_data_r  <= 8'd0;
          ts_ena_r   <= 1'b0;
          ts_psync_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pk_start   = pk_start_r;
  assign bus.pk_pointer = pk_pointer_r;
  assign bus.ts_data    = ts_data_r;
  assign bus.ts_ena     = ts_ena_r;
  assign bus.ts_psync   = ts_psync_r;
  assign bus.slot_miss  = slot_miss_r;
  assign bus.lq_ovf     = lq_ovf_r;

endmodule
